fp_divsqrt_arbiter: RTL and testbench
=====================================

// Module: fp_divsqrt_arbiter
// PURPOSE
//  Shares one iterative mantissa divide/square-root core between the FP divide and FP sqrt requesters.
//  Grants one requester at a time, with round-robin priority when both request in the same cycle.
//  Sequences the core: load pulse, then a fixed-latency run, then result capture and a done pulse.
//  Holds the pipeline stall while an operation is pending.
//  Sits in FP_Unit between FP_Div/FP_Sqrt front-ends and the shared mantissa core.
// PARAMETERS
//  WIDTH    53  width of core result / out_result (mantissa + guard bits)
//  LATENCY  11  core run cycles after load before in_core_result is valid (>=1)
//  CNT_W    4   run-counter width; must satisfy 2**CNT_W > LATENCY
// PORTS
//  in_Clk          input   1      clock, rising edge
//  in_Rst_N        input   1      asynchronous, active-low reset
//  in_stall        input   1      global pipeline freeze (also drives core stall)
//  in_div_req      input   1      divide requester wants the core; level, held until done
//  in_sqrt_req     input   1      sqrt requester wants the core; level, held until done
//  in_core_result  input   WIDTH  core output, valid in last RUN cycle
//  out_core_load   output  1      core operand load strobe
//  out_core_op     output  1      0 = divide, 1 = sqrt; valid whenever out_busy
//  out_result      output  WIDTH  registered captured result
//  out_div_done    output  1      divide result valid in out_result
//  out_sqrt_done   output  1      sqrt result valid in out_result
//  out_stall       output  1      stall request to pipeline
//  out_busy        output  1      core owned by a requester
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt=0, grant=0, last_grant=1 (divide wins first tie), out_result=0.
//    All outputs are 0 while in_Rst_N is low.
//    Reset mid-operation abandons the operation; no done pulse is issued.
//  FSM (advances only when in_stall=0; otherwise state, cnt, grant and out_result hold):
//   IDLE: no request -> IDLE.
//    One request -> grant it.
//    Both requests -> grant = ~last_grant.
//    On any grant -> LOAD.
//   LOAD: out_core_load=1; cnt<=0 -> RUN.
//   RUN: cnt<=cnt+1. When cnt==LATENCY-1: out_result<=in_core_result, last_grant<=grant, -> DONE.
//   DONE: out_div_done = (grant==0); out_sqrt_done = (grant==1) -> IDLE.
//  Decoded outputs:
//    out_core_load, out_*_done and out_busy (state!=IDLE) are decoded from state.
//    They stay asserted across stalled cycles.
//    Consumers qualify them with !in_stall.
//  out_core_op = grant.
//  out_stall = (in_div_req|in_sqrt_req) & (state!=DONE); combinational.
//    Unstalls the pipeline exactly in the DONE cycle.
//  Latency: request seen in IDLE at T0 -> LOAD T1 -> RUN T2..T(LATENCY+1) -> DONE T(LATENCY+2).
//    Default: done at T13, excluding stalled cycles.
//  Request dropped mid-operation: no abort. The operation completes and done still pulses.
//  Request present in LOAD/RUN/DONE from the non-granted side:
//    waits; it is arbitrated in the next IDLE cycle.
//  Back-to-back operations: a minimum 1-cycle IDLE bubble between DONE and the next LOAD.
//  Stall asserted in DONE: done stays high and out_result holds until the stall releases.
// TESTING
//  1 Div only: in_div_req=1 at T0, no stall -> load at T1 only, op=0.
//    in_core_result=0x1A5 at T12 -> out_result=0x1A5, out_div_done at T13, out_stall low at T13.
//  2 Tie: div and sqrt requested together from reset.
//    -> div served first (done at T13); sqrt loaded at T15 with op=1; sqrt done at T27.
//  3 Stall: in_stall=1 for 3 cycles during RUN (cnt=5).
//    -> cnt frozen at 5, done delayed to T16, result unchanged by stalled cycles.
//  4 Reset mid-RUN: in_Rst_N low at T6 -> all outputs 0 immediately.
//    After release with no request: IDLE, no done pulse.
//  5 Dropped request: in_sqrt_req deasserted at T4.
//    -> operation completes, out_sqrt_done at T13, out_stall low from T4.
//  6 LATENCY=1 build: done 3 cycles after request; cnt compare never wraps.

Source files
------------

// File: rtl/fp_divsqrt_arbiter_if.sv
// Handshake bundle between the FP divide/sqrt front-ends, the shared mantissa core
// and the divide/sqrt arbiter.
interface fp_divsqrt_arbiter_if #(
    parameter int WIDTH = 53
);
    logic             in_stall;
    logic             in_div_req;
    logic             in_sqrt_req;
    logic [WIDTH-1:0] in_core_result;
    logic             out_core_load;
    logic             out_core_op;
    logic [WIDTH-1:0] out_result;
    logic             out_div_done;
    logic             out_sqrt_done;
    logic             out_stall;
    logic             out_busy;

    modport master (
        output in_stall, in_div_req, in_sqrt_req, in_core_result,
        input  out_core_load, out_core_op, out_result,
        input  out_div_done, out_sqrt_done, out_stall, out_busy
    );

    modport slave (
        input  in_stall, in_div_req, in_sqrt_req, in_core_result,
        output out_core_load, out_core_op, out_result,
        output out_div_done, out_sqrt_done, out_stall, out_busy
    );
endinterface

// File: rtl/fp_divsqrt_arbiter.sv
// Round-robin owner of the shared iterative mantissa divide/sqrt core: grants one
// requester, sequences load/run/capture and reports completion, holding the pipeline stall meanwhile.
module fp_divsqrt_arbiter #(
    parameter int WIDTH   = 53,
    parameter int LATENCY = 11,
    parameter int CNT_W   = 4
) (
    input  logic                 in_Clk,
    input  logic                 in_Rst_N,
    fp_divsqrt_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(LATENCY - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             grant_r;
    logic             last_grant_r;
    logic [WIDTH-1:0] result_r;
    logic             any_req_s;
    logic             grant_pick_s;
    logic             run_last_s;

    assign any_req_s  = bus.in_div_req | bus.in_sqrt_req;
    assign run_last_s = (cnt_r == RUN_LAST);

    // A tie goes to the side that was not served last; a lone request simply wins.
    always_comb begin
        grant_pick_s = 1'b0;
        if (bus.in_div_req && bus.in_sqrt_req) begin
            grant_pick_s = ~last_grant_r;
        end else if (bus.in_sqrt_req) begin
            grant_pick_s = 1'b1;
        end else begin
            grant_pick_s = 1'b0;
        end
    end

    // State register; a pipeline freeze holds the sequencer where it is.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            state_r <= ST_IDLE;
        end else if (!bus.in_stall) begin
            state_r <= state_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state sequencing through load, fixed-length run and done.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (run_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Grant, run counter, tie history and captured result; all frozen under stall.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            cnt_r        <= {CNT_W{1'b0}};
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            result_r     <= {WIDTH{1'b0}};
        end else if (!bus.in_stall) begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r <= grant_pick_s;
                    end else begin
                        grant_r <= grant_r;
                    end
                end
                ST_LOAD: cnt_r <= {CNT_W{1'b0}};
                ST_RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (run_last_s) begin
                        result_r     <= bus.in_core_result;
                        last_grant_r <= grant_r;
                    end else begin
                        result_r     <= result_r;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Outputs decoded from the state register; stall is gated so reset forces it low.
    always_comb begin
        bus.out_core_load = 1'b0;
        bus.out_div_done  = 1'b0;
        bus.out_sqrt_done = 1'b0;
        bus.out_busy      = (state_r != ST_IDLE);
        bus.out_core_op   = grant_r;
        bus.out_result    = result_r;
        bus.out_stall     = in_Rst_N & any_req_s & (state_r != ST_DONE);
        case (state_r)
            ST_LOAD: bus.out_core_load = 1'b1;
            ST_DONE: begin
                bus.out_div_done  = ~grant_r;
                bus.out_sqrt_done = grant_r;
            end
            default: bus.out_core_load = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// Scoreboard bench for fp_divsqrt_arbiter: a transaction-level model predicts per-cycle
// control outputs and completed results; a negedge monitor pops and compares.
module tb_fp_divsqrt_arbiter;
    localparam int WIDTH   = 53;
    localparam int LATENCY = 11;
    localparam int CNT_W   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_divsqrt_arbiter_if #(.WIDTH(WIDTH)) bus ();
    fp_divsqrt_arbiter_if #(.WIDTH(WIDTH)) bus1 ();

    fp_divsqrt_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .in_Clk(clk), .in_Rst_N(rst_n), .bus(bus));
    fp_divsqrt_arbiter #(.WIDTH(WIDTH), .LATENCY(1), .CNT_W(1)) dut1 (
        .in_Clk(clk), .in_Rst_N(rst_n), .bus(bus1));

    typedef struct {
        bit stall; bit busy; bit load; bit div_done; bit sqrt_done; bit op;
    } cyc_t;
    typedef struct {
        bit op; logic [WIDTH-1:0] res;
    } res_t;

    cyc_t cyc_q[$];
    res_t res_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Transaction-level model: an owner and a count of unstalled cycles since its grant.
    bit m_busy;
    bit m_owner;
    int m_age;
    bit m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_age   = 0;
        m_last  = 1'b1;
    endtask

    task automatic step(input bit stall, input bit div, input bit sqrt,
                        input logic [WIDTH-1:0] res, output bit dd, output bit sd);
        cyc_t e;
        bit   at_done;
        at_done     = m_busy && (m_age == LATENCY + 2);
        e.stall     = (div | sqrt) && !at_done;
        e.busy      = m_busy;
        e.load      = m_busy && (m_age == 1);
        e.div_done  = at_done && !m_owner;
        e.sqrt_done = at_done && m_owner;
        e.op        = m_owner;
        cyc_q.push_back(e);
        dd = 1'b0;
        sd = 1'b0;
        if (!stall) begin
            if (!m_busy) begin
                if (div | sqrt) begin
                    m_owner = (div && sqrt) ? ~m_last : sqrt;
                    m_busy  = 1'b1;
                    m_age   = 1;
                end
            end else if (at_done) begin
                m_busy = 1'b0;
                m_last = m_owner;
                dd     = ~m_owner;
                sd     = m_owner;
            end else begin
                if (m_age == LATENCY + 1) res_q.push_back('{m_owner, res});
                m_age++;
            end
        end
    endtask

    task automatic cycle(input bit stall, input bit div, input bit sqrt,
                         output bit dd, output bit sd);
        logic [63:0] r;
        @(posedge clk);
        #1;
        r = {$urandom, $urandom};
        bus.in_stall       = stall;
        bus.in_div_req     = div;
        bus.in_sqrt_req    = sqrt;
        bus.in_core_result = r[WIDTH-1:0];
        step(stall, div, sqrt, r[WIDTH-1:0], dd, sd);
    endtask

    // Monitor: compare every modelled cycle, and each qualified done against the result queue.
    always @(negedge clk) begin
        if (rst_n && cyc_q.size() > 0) begin
            cyc_t e;
            e = cyc_q.pop_front();
            check("stall", bus.out_stall, e.stall);
            check("busy", bus.out_busy, e.busy);
            check("load", bus.out_core_load, e.load);
            check("div_done", bus.out_div_done, e.div_done);
            check("sqrt_done", bus.out_sqrt_done, e.sqrt_done);
            if (e.busy) check("op", bus.out_core_op, e.op);
            if ((bus.out_div_done || bus.out_sqrt_done) && !bus.in_stall) begin
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_result: done with no predicted result at %0t", $time);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("done_op", bus.out_sqrt_done, r.op);
                    check("result", bus.out_result, r.res);
                end
            end
        end
    end

    initial begin
        bit want_div, want_sqrt, dd, sd, rst_done;
        int quiet, n;
        bus.in_stall = 1'b0; bus.in_div_req = 1'b0; bus.in_sqrt_req = 1'b0;
        bus.in_core_result = '0;
        bus1.in_stall = 1'b0; bus1.in_div_req = 1'b0; bus1.in_sqrt_req = 1'b0;
        bus1.in_core_result = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.out_busy, 1'b0);
        check("rst_result", bus.out_result, 64'd0);
        check("rst_stall", bus.out_stall, 1'b0);
        rst_n = 1'b1;

        // Tie from reset: divide first, sqrt after a one-cycle idle bubble.
        want_div = 1'b1; want_sqrt = 1'b1;
        for (int i = 0; i < 34; i++) begin
            cycle(1'b0, want_div, want_sqrt, dd, sd);
            if (dd) want_div = 1'b0;
            if (sd) want_sqrt = 1'b0;
        end

        // Randomized traffic with stalls, dropped requests and one mid-run reset.
        rst_done = 1'b0;
        quiet    = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!rst_done && i >= 1200 && m_busy && m_age >= 3 && m_age <= 8) begin
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                check("rrst_busy", bus.out_busy, 1'b0);
                check("rrst_load", bus.out_core_load, 1'b0);
                check("rrst_op", bus.out_core_op, 1'b0);
                check("rrst_result", bus.out_result, 64'd0);
                check("rrst_ddone", bus.out_div_done, 1'b0);
                check("rrst_sdone", bus.out_sqrt_done, 1'b0);
                check("rrst_stall", bus.out_stall, 1'b0);
                want_div = 1'b0; want_sqrt = 1'b0;
                bus.in_div_req = 1'b0; bus.in_sqrt_req = 1'b0; bus.in_stall = 1'b0;
                @(posedge clk);
                #1;
                cyc_q.delete();
                res_q.delete();
                model_reset();
                rst_n    = 1'b1;
                rst_done = 1'b1;
                quiet    = 20;
                continue;
            end
            if (quiet > 0) begin
                quiet--;
            end else begin
                if (!want_div && $urandom_range(0, 7) == 0) want_div = 1'b1;
                if (!want_sqrt && $urandom_range(0, 7) == 0) want_sqrt = 1'b1;
                if (want_div && $urandom_range(0, 59) == 0) want_div = 1'b0;
                if (want_sqrt && $urandom_range(0, 59) == 0) want_sqrt = 1'b0;
            end
            cycle($urandom_range(0, 99) < 20, want_div, want_sqrt, dd, sd);
            if (dd) want_div = 1'b0;
            if (sd) want_sqrt = 1'b0;
        end

        // Drain any operation in flight so every predicted result is seen.
        for (int i = 0; i < LATENCY + 6; i++) cycle(1'b0, 1'b0, 1'b0, dd, sd);
        @(negedge clk);
        check("res_q_drained", res_q.size(), 64'd0);
        check("reset_exercised", rst_done, 1'b1);

        // LATENCY=1 build: done three cycles after the request.
        @(posedge clk);
        #1;
        bus1.in_div_req     = 1'b1;
        bus1.in_core_result = 53'h1A5;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (bus1.out_div_done) begin
                n = k;
                break;
            end
        end
        check("lat1_done_cycle", n, 64'd3);
        check("lat1_result", bus1.out_result, 64'h1A5);
        check("lat1_stall_in_done", bus1.out_stall, 1'b0);
        bus1.in_div_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
